// File: rtl/ram_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_seq_pkg
// Description : Shared state encoding, address field widths and default
//               timing parameters for the DRAM access sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_seq_pkg;

    localparam int c_row_w              = 11;
    localparam int c_col_w              = 10;
    localparam int c_ra_w               = 11;
    localparam int c_ref_interval_def   = 375;
    localparam int c_pre_cycles_def     = 2;
    localparam int c_ref_ras_cycles_def = 3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ROW  = 3'd1,
        S_COL  = 3'd2,
        S_CAS  = 3'd3,
        S_HOLD = 3'd4,
        S_PRE  = 3'd5,
        S_RCAS = 3'd6,
        S_RRAS = 3'd7
    } ram_state_t;

endpackage
`default_nettype wire

// File: rtl/ram_refresh_timer.sv
`default_nettype none
// ============================================================================
// Module      : ram_refresh_timer
// Description : Free-running refresh interval counter with a single-bit
//               pending flag, cleared when the sequencer starts a refresh.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_refresh_timer #(
    parameter int REF_INTERVAL = 375
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_pending
);

    localparam int                c_cnt_w = $clog2(REF_INTERVAL);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(REF_INTERVAL - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_pending;

    // A fresh expiry wins over a simultaneous clear so no interval is skipped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else if (r_cnt == c_last) begin
            r_cnt     <= '0;
            r_pending <= 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (i_clr) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/ram_seq.sv
`default_nettype none
// ============================================================================
// Module      : ram_seq
// Description : 68000-side DRAM access sequencer with registered RAS/CAS/WE
//               strobes; CAS-before-RAS refresh when RAM_REFRESH_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_seq
    import ram_seq_pkg::*;
#(
    parameter int REF_INTERVAL   = c_ref_interval_def,
    parameter int PRE_CYCLES     = c_pre_cycles_def,
    parameter int REF_RAS_CYCLES = c_ref_ras_cycles_def
) (
    input  logic              CLK,
    input  logic              RES,
    input  logic [21:1]       A,
    input  logic              nWE,
    input  logic              nUDS,
    input  logic              nLDS,
    input  logic              RAMCS,
    input  logic              BACT,
    output logic [c_ra_w-1:0] RA,
    output logic              nRAS,
    output logic              nCASH,
    output logic              nCASL,
    output logic              nRAMWE,
    output logic              RAMReady,
    output logic              RefBusy
);

    localparam logic [2:0] c_pre_last = 3'(PRE_CYCLES - 1);
    localparam logic [2:0] c_ras_last = 3'(REF_RAS_CYCLES - 1);

    if (PRE_CYCLES < 1 || PRE_CYCLES > 7 || REF_RAS_CYCLES < 1 || REF_RAS_CYCLES > 7
        || REF_INTERVAL < 2) begin : g_bad_param
        $error("ram_seq: timing parameter out of range");
    end

    ram_state_t        r_state;
    ram_state_t        w_next;
    ram_state_t        w_decide;
    logic [2:0]        r_cnt;
    logic              r_ref;
    logic              r_we_n;
    logic              w_pending;
    logic              w_ref_clr;
    logic [c_ra_w-1:0] w_row;
    logic [c_ra_w-1:0] w_col;
    logic [c_ra_w-1:0] w_ra;
    logic              w_ras_n;
    logic              w_cash_n;
    logic              w_casl_n;
    logic              w_we_n;
    logic              w_ready;
    logic              w_busy;

    assign w_row     = A[21:11];
    assign w_col     = {1'b0, A[10:1]};
    assign w_ref_clr = (r_state == S_RCAS);

`ifdef RAM_REFRESH_EN
    ram_refresh_timer #(
        .REF_INTERVAL(REF_INTERVAL)
    ) u_refresh_timer (
        .clk      (CLK),
        .rst      (RES),
        .i_clr    (w_ref_clr),
        .o_pending(w_pending)
    );
`else
    assign w_pending = 1'b0;
`endif

    // Refresh outranks a CPU request; PRE reuses this so a back-to-back
    // access sees exactly PRE_CYCLES of nRAS high.
    always_comb begin
        w_decide = S_IDLE;
        if (w_pending) begin
            w_decide = S_RCAS;
        end else if (RAMCS && BACT) begin
            w_decide = S_ROW;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: w_next = w_decide;
            S_ROW:  w_next = BACT ? S_COL : S_PRE;
            S_COL:  w_next = BACT ? S_CAS : S_PRE;
            S_CAS:  w_next = S_HOLD;
            S_HOLD: w_next = BACT ? S_HOLD : S_PRE;
            S_PRE:  w_next = (r_cnt == c_pre_last) ? w_decide : S_PRE;
            S_RCAS: w_next = S_RRAS;
            S_RRAS: w_next = (r_cnt == c_ras_last) ? S_PRE : S_RRAS;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ref   <= 1'b0;
            r_we_n  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? 3'd0 : r_cnt + 3'd1;
            if (w_next == S_RCAS) begin
                r_ref <= 1'b1;
            end else if (w_next == S_ROW || w_next == S_IDLE) begin
                r_ref <= 1'b0;
            end
            if (w_next == S_ROW && r_state != S_ROW) begin
                r_we_n <= nWE;
            end
        end
    end

    // Output decode from the current state; registered below, so every
    // strobe trails its state by one clock.
    always_comb begin
        w_ra     = RA;
        w_ras_n  = 1'b1;
        w_cash_n = 1'b1;
        w_casl_n = 1'b1;
        w_we_n   = 1'b1;
        w_ready  = 1'b0;
        w_busy   = 1'b0;
        case (r_state)
            S_ROW: begin
                w_ra    = w_row;
                w_ras_n = 1'b0;
                w_we_n  = r_we_n;
            end
            S_COL: begin
                w_ra    = w_col;
                w_ras_n = 1'b0;
                w_we_n  = r_we_n;
            end
            S_CAS: begin
                w_ras_n  = 1'b0;
                w_cash_n = nUDS;
                w_casl_n = nLDS;
                w_we_n   = r_we_n;
                w_ready  = 1'b1;
            end
            S_HOLD: begin
                w_ras_n  = 1'b0;
                w_cash_n = nCASH;
                w_casl_n = nCASL;
                w_we_n   = r_we_n;
            end
            S_PRE: begin
                w_busy = r_ref;
            end
            S_RCAS: begin
                w_cash_n = 1'b0;
                w_casl_n = 1'b0;
                w_busy   = 1'b1;
            end
            S_RRAS: begin
                w_ras_n  = 1'b0;
                w_cash_n = 1'b0;
                w_casl_n = 1'b0;
                w_busy   = 1'b1;
            end
            default: begin
                w_ra = RA;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            RA       <= '0;
            nRAS     <= 1'b1;
            nCASH    <= 1'b1;
            nCASL    <= 1'b1;
            nRAMWE   <= 1'b1;
            RAMReady <= 1'b0;
            RefBusy  <= 1'b0;
        end else begin
            RA       <= w_ra;
            nRAS     <= w_ras_n;
            nCASH    <= w_cash_n;
            nCASL    <= w_casl_n;
            nRAMWE   <= w_we_n;
            RAMReady <= w_ready;
            RefBusy  <= w_busy;
        end
    end

endmodule
`default_nettype wire
